pc_sequencer: RTL and testbench

Controls the ProgramCounter register and drives the instruction-fetch handshake of the MIPS processor. It chooses the next PC (sequential, branch, jump or exception vector), issues one fetch at a time to instruction memory, and holds each fetched instruction until decode accepts it. Stall and redirect requests from decode and execute all go through this block. Nothing else writes the PC.

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter owner and single-outstanding instruction-fetch sequencer.
// Chooses the next PC and holds each fetched word until decode takes it.
module pc_sequencer #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR   = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              decode_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exception,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        fsm_state
);

  // Handshakes: imem_req/imem_addr stay stable until imem_ack (or an
  // exception withdraws the request); instr_valid/instr/instr_pc stay stable
  // until the cycle where decode_ready=1 and stall=0 (the acceptance cycle).
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  logic              accept;
  logic [ADDR_W-1:0] next_pc;

  assign imem_addr = pc;
  assign fsm_state = state;
  assign accept    = decode_ready && !stall;

  always_comb begin
    next_pc = pc + ADDR_W'(4);
    if (jump)
      next_pc = jump_target & ALIGN_MASK;
    else if (branch_taken)
      next_pc = branch_target & ALIGN_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          // An exception outranks a same-cycle ack; that data is dropped.
          if (exception) begin
            pc          <= EXC_VECTOR;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (exception) begin
            pc          <= EXC_VECTOR;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end else if (accept) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= BOOT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch stream, memory wait, stall,
// redirect priority, exception discard, PC wrap and mid-run reset.
module tb_pc_sequencer;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic [31:0] pc;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  // memory model: instruction word is a fixed function of its address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  assign imem_rdata = word_at(imem_addr);

  pc_sequencer dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .decode_ready(decode_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .exception(exception), .pc(pc), .fsm_state(fsm_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_ack = 0; decode_ready = 0; stall = 0;
    branch_taken = 0; branch_target = 0;
    jump = 0; jump_target = 0; exception = 0;
  endtask

  // leaves the DUT in FETCH at pc=0
  task automatic do_reset();
    reset = 1;
    clear_inputs();
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {30'd0, fsm_state}, {30'd0, S_BOOT});
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    tick();
    reset = 0;
    tick();
    chk("boot_to_fetch", {30'd0, fsm_state}, {30'd0, S_FETCH});

    // 1: immediate ack, decode always ready -> 0,4,8,12,16 every 2 cycles
    imem_ack = 1; decode_ready = 1;
    for (int k = 0; k < 5; k++) begin
      chk("seq_req", {31'd0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      chk("seq_valid_lo", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("seq_valid_hi", {31'd0, instr_valid}, 32'd1);
      chk("seq_instr_pc", instr_pc, 32'(4 * k));
      chk("seq_instr", instr, word_at(32'(4 * k)));
      chk("seq_req_lo", {31'd0, imem_req}, 32'd0);
      tick();
    end

    // 2: memory holds off ack for 3 cycles at pc=8
    do_reset();
    imem_ack = 1; decode_ready = 1;
    tick(); tick(); tick(); tick();
    imem_ack = 0;
    for (int k = 0; k < 3; k++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_pc", pc, 32'h8);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    imem_ack = 1;
    chk("wait_ack_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("wait_done_valid", {31'd0, instr_valid}, 32'd1);
    chk("wait_done_pc", instr_pc, 32'h8);

    // 3: stalled in HOLD at pc=4; branch during stall must be ignored
    do_reset();
    imem_ack = 1; decode_ready = 1;
    tick(); tick(); tick();
    imem_ack = 0; stall = 1; branch_taken = 1; branch_target = 32'h40;
    for (int k = 0; k < 4; k++) begin
      chk("stall_state", {30'd0, fsm_state}, {30'd0, S_HOLD});
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr_pc", instr_pc, 32'h4);
      chk("stall_instr", instr, word_at(32'h4));
      tick();
    end
    stall = 0; branch_taken = 0;
    tick();
    chk("stall_next_addr", imem_addr, 32'h8);

    // 4: jump outranks branch; target low bits cleared
    do_reset();
    imem_ack = 1; decode_ready = 1;
    tick(); tick(); tick();
    jump = 1; jump_target = 32'h103; branch_taken = 1; branch_target = 32'h200;
    tick();
    chk("jump_addr", imem_addr, 32'h100);
    chk("jump_req", {31'd0, imem_req}, 32'd1);
    jump = 0; branch_taken = 0;

    // 5: exception with same-cycle ack at pc=12
    do_reset();
    imem_ack = 1; decode_ready = 1;
    for (int k = 0; k < 6; k++) tick();
    chk("pre_exc_addr", imem_addr, 32'hC);
    exception = 1;
    tick();
    exception = 0;
    chk("exc_valid", {31'd0, instr_valid}, 32'd0);
    chk("exc_addr", imem_addr, 32'h80);
    chk("exc_state", {30'd0, fsm_state}, {30'd0, S_FETCH});
    chk("exc_req", {31'd0, imem_req}, 32'd1);
    chk("exc_instr", instr, word_at(32'h8));

    // 6: PC wrap from FFFF_FFFC
    tick();
    jump = 1; jump_target = 32'hFFFF_FFFF;
    tick();
    jump = 0;
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_top_instr_pc", instr_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);

    // 7: reset asserted in HOLD at pc=4
    tick(); tick(); tick();
    chk("pre_rst_state", {30'd0, fsm_state}, {30'd0, S_HOLD});
    chk("pre_rst_pc", pc, 32'h4);
    reset = 1;
    tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_state", {30'd0, fsm_state}, {30'd0, S_BOOT});
    chk("mid_rst_instr_pc", instr_pc, 32'h0);

    // 8: exception in BOOT is ignored
    reset = 0; exception = 1;
    tick();
    exception = 0;
    chk("boot_exc_state", {30'd0, fsm_state}, {30'd0, S_FETCH});
    chk("boot_exc_pc", pc, 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
